// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use/branch stalls, decode flush and syscall drain/issue/wait sequencing.
// Forward/stall outputs are combinational this cycle; FSM, drain counter and syscall_go are registered; optional HAZARD_PERF_CNT_EN counters.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       BranchD,
  input  logic       pc_src_d,
  input  logic       syscallD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic       MemtoRegE,
  input  logic       RegWriteE,
  input  logic [4:0] WriteRegM,
  input  logic       MemtoRegM,
  input  logic       RegWriteM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteW,
  input  logic       syscall_done,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       syscall_go,
  output logic       busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] lwstall_cnt,
  output logic [31:0] brstall_cnt,
  output logic [31:0] syscall_cyc_cnt
`endif
);

  localparam int CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [2:0] StRun    = 3'd0;
  localparam logic [2:0] StDrain  = 3'd1;
  localparam logic [2:0] StIssue  = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StResume = 3'd4;

  logic [2:0]      state;
  logic [2:0]      stateNxt;
  logic [CntW-1:0] drainCnt;
  logic            syscallGoQ;
  logic            lwStall;
  logic            brStall;
  logic            hazStall;

  assign lwStall = MemtoRegE && RegWriteE && (WriteRegE != 5'd0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign brStall = BranchD &&
                   ((RegWriteE && (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
  assign hazStall = lwStall | brStall;

  always_comb begin
    stateNxt = state;
    case (state)
      StRun:    if (syscallD && !hazStall) stateNxt = StDrain;
      StDrain:  if (drainCnt == '0) stateNxt = StIssue;
      StIssue:  stateNxt = StWait;
      StWait:   if (syscall_done) stateNxt = StResume;
      StResume: stateNxt = StRun;
      default:  stateNxt = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StRun;
      drainCnt   <= '0;
      syscallGoQ <= 1'b0;
    end else begin
      state      <= stateNxt;
      syscallGoQ <= (stateNxt == StIssue);
      if (state == StRun && stateNxt == StDrain)
        drainCnt <= CntW'(DRAIN_CYCLES - 1);
      else if (state == StDrain && drainCnt != '0)
        drainCnt <= drainCnt - 1'b1;
    end
  end

  assign syscall_go = syscallGoQ;

  // Reset overrides everything so the fetch register is cleared while the core is held.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    busy      = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
    end else begin
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))      ForwardAE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE)) ForwardAE = 2'b01;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))      ForwardBE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE)) ForwardBE = 2'b01;
      ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
      ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);
      case (state)
        StRun: begin
          StallF = hazStall;
          StallD = hazStall;
          FlushE = !hazStall;
          FlushD = pc_src_d && !hazStall;
        end
        StResume: busy = 1'b1;
        default: begin
          StallF = 1'b1;
          StallD = 1'b1;
          busy   = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      lwstall_cnt     <= '0;
      brstall_cnt     <= '0;
      syscall_cyc_cnt <= '0;
    end else if (state == StRun) begin
      if (lwStall) begin
        if (lwstall_cnt != 32'hFFFFFFFF) lwstall_cnt <= lwstall_cnt + 32'd1;
      end else if (brStall) begin
        if (brstall_cnt != 32'hFFFFFFFF) brstall_cnt <= brstall_cnt + 32'd1;
      end
    end else if (syscall_cyc_cnt != 32'hFFFFFFFF) begin
      syscall_cyc_cnt <= syscall_cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios plus random traffic checked against a cycle-schedule model.
module tb_hazard_ctrl;
  localparam int DC = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, pc_src_d, syscallD, MemtoRegE, RegWriteE;
  logic       MemtoRegM, RegWriteM, RegWriteW, syscall_done;
  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, syscall_go, busy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lwstall_cnt, brstall_cnt, syscall_cyc_cnt;
`endif

  hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .pc_src_d(pc_src_d), .syscallD(syscallD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .syscall_done(syscall_done),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .syscall_go(syscall_go), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .lwstall_cnt(lwstall_cnt), .brstall_cnt(brstall_cnt), .syscall_cyc_cnt(syscall_cyc_cnt)
`endif
  );

  typedef struct packed {
    logic       reset;
    logic [4:0] RsD, RtD;
    logic       BranchD, pc_src_d, syscallD;
    logic [4:0] RsE, RtE, WriteRegE;
    logic       MemtoRegE, RegWriteE;
    logic [4:0] WriteRegM;
    logic       MemtoRegM, RegWriteM;
    logic [4:0] WriteRegW;
    logic       RegWriteW, syscall_done;
  } stim_t;

  typedef struct packed {
    logic        stallF, stallD, flushD, flushE;
    logic [1:0]  fAE, fBE;
    logic        fAD, fBD, go, busy;
    logic [31:0] lwc, brc, syc, cyc;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFail = 0;

  // Model state: a syscall is tracked by the cycle it was accepted and the cycle completion arrived.
  int          cyc = 0;
  int          sysStart = -1;
  int          doneCyc = -1;
  logic [31:0] mLw = 0, mBr = 0, mSy = 0;

  function automatic logic [1:0] fwdE(input stim_t s, input logic [4:0] src);
    if (s.RegWriteM && s.WriteRegM != 0 && s.WriteRegM == src) return 2'b10;
    if (s.RegWriteW && s.WriteRegW != 0 && s.WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input stim_t s);
    exp_t  e;
    string ph;
    logic  lw, br;
    @(posedge clock);
    #1;
    reset = s.reset; RsD = s.RsD; RtD = s.RtD; BranchD = s.BranchD; pc_src_d = s.pc_src_d;
    syscallD = s.syscallD; RsE = s.RsE; RtE = s.RtE; WriteRegE = s.WriteRegE;
    MemtoRegE = s.MemtoRegE; RegWriteE = s.RegWriteE; WriteRegM = s.WriteRegM;
    MemtoRegM = s.MemtoRegM; RegWriteM = s.RegWriteM; WriteRegW = s.WriteRegW;
    RegWriteW = s.RegWriteW; syscall_done = s.syscall_done;

    if (sysStart < 0)                  ph = "RUN";
    else if (cyc <= sysStart + DC)     ph = "DRAIN";
    else if (cyc == sysStart + DC + 1) ph = "ISSUE";
    else if (doneCyc < 0)              ph = "WAIT";
    else                               ph = "RESUME";

    lw = s.MemtoRegE && s.RegWriteE && s.WriteRegE != 0 &&
         (s.WriteRegE == s.RsD || s.WriteRegE == s.RtD);
    br = s.BranchD && ((s.RegWriteE && s.WriteRegE != 0 && (s.WriteRegE == s.RsD || s.WriteRegE == s.RtD)) ||
                       (s.MemtoRegM && s.WriteRegM != 0 && (s.WriteRegM == s.RsD || s.WriteRegM == s.RtD)));

    e = '0;
    e.cyc = cyc;
    e.go  = (ph == "ISSUE");
    e.lwc = mLw; e.brc = mBr; e.syc = mSy;
    if (s.reset) begin
      e.flushD = 1'b1;
    end else begin
      e.fAE = fwdE(s, s.RsE);
      e.fBE = fwdE(s, s.RtE);
      e.fAD = s.RsD != 0 && s.RegWriteM && s.WriteRegM == s.RsD;
      e.fBD = s.RtD != 0 && s.RegWriteM && s.WriteRegM == s.RtD;
      if (ph == "RUN") begin
        e.stallF = lw | br; e.stallD = lw | br;
        e.flushE = !(lw | br);
        e.flushD = s.pc_src_d && !(lw | br);
      end else if (ph == "RESUME") begin
        e.busy = 1'b1;
      end else begin
        e.stallF = 1'b1; e.stallD = 1'b1; e.busy = 1'b1;
      end
    end
    expQ.push_back(e);

    if (s.reset) begin
      sysStart = -1; doneCyc = -1; mLw = 0; mBr = 0; mSy = 0;
    end else begin
      if (ph == "RUN") begin
        if (lw) begin if (mLw != 32'hFFFFFFFF) mLw++; end
        else if (br) begin if (mBr != 32'hFFFFFFFF) mBr++; end
        if (s.syscallD && !(lw | br)) begin sysStart = cyc; doneCyc = -1; end
      end else if (mSy != 32'hFFFFFFFF) mSy++;
      if (ph == "WAIT" && s.syscall_done) doneCyc = cyc;
      if (ph == "RESUME") sysStart = -1;
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input logic [31:0] c);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("StallF", 32'(StallF), 32'(e.stallF), e.cyc);
        chk("StallD", 32'(StallD), 32'(e.stallD), e.cyc);
        chk("FlushD", 32'(FlushD), 32'(e.flushD), e.cyc);
        chk("FlushE", 32'(FlushE), 32'(e.flushE), e.cyc);
        chk("ForwardAE", 32'(ForwardAE), 32'(e.fAE), e.cyc);
        chk("ForwardBE", 32'(ForwardBE), 32'(e.fBE), e.cyc);
        chk("ForwardAD", 32'(ForwardAD), 32'(e.fAD), e.cyc);
        chk("ForwardBD", 32'(ForwardBD), 32'(e.fBD), e.cyc);
        chk("syscall_go", 32'(syscall_go), 32'(e.go), e.cyc);
        chk("busy", 32'(busy), 32'(e.busy), e.cyc);
`ifdef HAZARD_PERF_CNT_EN
        chk("lwstall_cnt", lwstall_cnt, e.lwc, e.cyc);
        chk("brstall_cnt", brstall_cnt, e.brc, e.cyc);
        chk("syscall_cyc_cnt", syscall_cyc_cnt, e.syc, e.cyc);
`endif
      end
    end
  end

  function automatic stim_t randStim();
    stim_t s;
    s.reset        = ($urandom_range(0, 79) == 0);
    s.RsD          = 5'($urandom_range(0, 7));
    s.RtD          = 5'($urandom_range(0, 7));
    s.BranchD      = ($urandom_range(0, 3) == 0);
    s.pc_src_d     = ($urandom_range(0, 3) == 0);
    s.syscallD     = ($urandom_range(0, 5) == 0);
    s.RsE          = 5'($urandom_range(0, 7));
    s.RtE          = 5'($urandom_range(0, 7));
    s.WriteRegE    = 5'($urandom_range(0, 7));
    s.MemtoRegE    = ($urandom_range(0, 2) == 0);
    s.RegWriteE    = ($urandom_range(0, 1) == 0);
    s.WriteRegM    = 5'($urandom_range(0, 7));
    s.MemtoRegM    = ($urandom_range(0, 2) == 0);
    s.RegWriteM    = ($urandom_range(0, 1) == 0);
    s.WriteRegW    = 5'($urandom_range(0, 7));
    s.RegWriteW    = ($urandom_range(0, 1) == 0);
    s.syscall_done = ($urandom_range(0, 4) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 1'b1; RsD = 0; RtD = 0; BranchD = 0; pc_src_d = 0; syscallD = 0;
    RsE = 0; RtE = 0; WriteRegE = 0; MemtoRegE = 0; RegWriteE = 0; WriteRegM = 0;
    MemtoRegM = 0; RegWriteM = 0; WriteRegW = 0; RegWriteW = 0; syscall_done = 0;
    @(posedge clock);

    s = '0; s.reset = 1'b1;
    drive(s); drive(s);

    // Load-use: lw $2 in E, add $3,$2,$4 in D, then the load reaches W as add enters E.
    s = '0; s.MemtoRegE = 1; s.RegWriteE = 1; s.WriteRegE = 2; s.RsD = 2; s.RtD = 4; drive(s);
    s = '0; s.MemtoRegM = 1; s.RegWriteM = 1; s.WriteRegM = 2; s.RsD = 2; s.RtD = 4; drive(s);
    s = '0; s.RegWriteW = 1; s.WriteRegW = 2; s.RsE = 2; s.RtE = 4; drive(s);

    s = '0; s.RegWriteM = 1; s.WriteRegM = 5; s.RegWriteW = 1; s.WriteRegW = 5; s.RsE = 5; s.RtE = 5; drive(s);
    s = '0; s.RegWriteM = 1; s.WriteRegM = 0; s.RegWriteW = 1; s.WriteRegW = 0; drive(s);

    s = '0; s.BranchD = 1; s.RsD = 7; s.RegWriteE = 1; s.WriteRegE = 7; s.pc_src_d = 1; drive(s);
    s = '0; s.BranchD = 1; s.RsD = 7; s.RegWriteM = 1; s.WriteRegM = 7; s.pc_src_d = 1; drive(s);

    // Syscall held in D through drain and wait, completion after a few WAIT cycles.
    s = '0; s.syscallD = 1; drive(s);
    for (int i = 0; i < 9; i++) drive(s);
    s.syscall_done = 1; drive(s);
    s.syscall_done = 0; drive(s);
    s = '0; drive(s); drive(s);

    // Reset while waiting, then a stale completion pulse.
    s = '0; s.syscallD = 1; drive(s);
    s = '0;
    for (int i = 0; i < 6; i++) drive(s);
    s.reset = 1; drive(s);
    s = '0; s.syscall_done = 1; drive(s);
    s = '0; drive(s); drive(s);

    for (int i = 0; i < 2000; i++) drive(randStim());

    @(posedge clock);
    @(negedge clock);
    #1;
    chk("queue_drained", 32'(expQ.size()), 32'd0, 32'(cyc));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It replaces the constant stall, flush and forward ties in the `cpu` top level. It drives forwarding selects, handles load-use and branch-compare stalls, and flushes decode on taken branches. It also sequences syscalls: the pipeline is drained, a one-cycle request goes to the syscall unit, and the controller waits for completion before resuming.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles held in DRAIN so older instructions retire through E/M/W.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- RsD, RtD  in  5  source register ids in decode
- BranchD  in  1  decode holds a branch/jump whose operands are compared in D
- pc_src_d  in  1  decode branch resolved taken
- syscallD  in  1  decode holds a syscall
- RsE, RtE, WriteRegE  in  5  execute register ids
- MemtoRegE, RegWriteE  in  1  execute control
- WriteRegM  in  5  memory destination id
- MemtoRegM, RegWriteM  in  1  memory control
- WriteRegW  in  5  writeback destination id
- RegWriteW  in  1  writeback control
- syscall_done  in  1  syscall unit completion pulse
- StallF, StallD  out  1  hold fetch PC / fetch pipe register
- FlushD  out  1  clear fetch pipe register (active-high)
- FlushE  out  1  execute bubble, ACTIVE-LOW (0 = flush), matching execute_stage
- ForwardAE, ForwardBE  out  2  00 register file, 01 ResultW, 10 ALUOutM
- ForwardAD, ForwardBD  out  1  branch-compare operand from ALUOutM
- syscall_go  out  1  one-cycle syscall request
- busy  out  1  FSM not in RUN

## Operation
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && WriteRegM!=0 && WriteRegM==RsE.
  - Otherwise 01 if RegWriteW && WriteRegW!=0 && WriteRegW==RsE.
  - Otherwise 00. ForwardBE uses the same rule on RtE.
  - M priority over W. Register 0 never forwards.
  - ForwardAD = RsD!=0 && RegWriteM && WriteRegM==RsD; ForwardBD likewise on RtD.
- lwstall = MemtoRegE && RegWriteE && WriteRegE!=0 && (WriteRegE==RsD || WriteRegE==RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD})).
- RUN:
  - StallF = StallD = lwstall|brstall.
  - FlushE = 0 when either stall is active, else 1.
  - FlushD = pc_src_d && !StallD.
  - syscallD && !lwstall && !brstall → DRAIN; counter loads DRAIN_CYCLES-1.
  - A stall and a syscall in the same cycle: the stall wins and the syscall is re-evaluated next cycle.
- DRAIN: StallF=StallD=1, FlushE=0; counter decrements; at 0 → ISSUE.
- ISSUE: stalls held, FlushE=0, syscall_go=1 for exactly one cycle → WAIT.
- WAIT: stalls held, FlushE=0; syscall_done → RESUME.
- RESUME (one cycle):
  - StallF=StallD=0, FlushE=0: the syscall leaves D as a bubble and is not re-triggered.
  - syscallD is ignored this cycle; → RUN.
- In all non-RUN states: FlushD=0, busy=1, and lwstall/brstall are ignored.
- syscall_done outside WAIT is ignored.

## Timing
- Forward and stall outputs are combinational from stage ids plus registered state, so they act in the same cycle.
- FSM state, drain counter and syscall_go are registered.
- Reset, sampled on the clock edge, puts the FSM in RUN with counter 0 and syscall_go=0.
- While reset is high: StallF=StallD=0, FlushD=1, FlushE=0, Forward*=0, busy=0.
- Reset in any state, including mid-DRAIN or WAIT, returns to RUN next edge. A pending syscall_done is discarded.
- Syscall latency: syscallD seen in RUN at cycle t:
  - DRAIN covers t+1..t+DRAIN_CYCLES.
  - syscall_go fires at t+DRAIN_CYCLES+1.
  - RESUME is the cycle after syscall_done is sampled.
- DRAIN_CYCLES ≥ 1. The counter is wide enough for DRAIN_CYCLES-1 and does not wrap.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs lwstall_cnt[31:0], brstall_cnt[31:0] and syscall_cyc_cnt[31:0].
  - lwstall_cnt and brstall_cnt increment in RUN cycles where that stall is asserted. When both fire in one cycle, lwstall_cnt increments and brstall_cnt does not.
  - syscall_cyc_cnt increments every non-RUN cycle.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- `lw $2,0($0)` in E, `add $3,$2,$4` in D (RsD=2) → StallF=StallD=1 and FlushE=0 for 1 cycle. On the next cycle ForwardAE=01.
- RegWriteM=1, WriteRegM=5 and RegWriteW=1, WriteRegW=5, with RsE=5 → ForwardAE=10. WriteRegM=0 with RsE=0 → ForwardAE=00.
- BranchD=1 with RsD=7 and RegWriteE=1, WriteRegE=7 → stall 1 cycle. Next cycle ForwardAD=1. pc_src_d=1 with no stall → FlushD=1.
- syscallD=1 at cycle 10, DRAIN_CYCLES=3:
  - DRAIN for cycles 11–13, syscall_go=1 only at cycle 14.
  - syscall_done at 20 → RESUME at 21 with stalls 0 and FlushE=0; RUN at 22.
  - syscall_go is never re-asserted.
- reset=1 during WAIT → RUN next edge, busy=0. A syscall_done pulse one cycle later has no effect.
- HAZARD_PERF_CNT_EN defined, 4 load-use stalls and 1 syscall waiting 6 cycles in WAIT (DRAIN_CYCLES=3) → lwstall_cnt=4 and syscall_cyc_cnt=11 (3 DRAIN + 1 ISSUE + 6 WAIT + 1 RESUME).
